compressor_seq_ctrl: RTL and testbench
======================================

COMPRESSOR_SEQ_CTRL -- requirements
Module: compressor_seq_ctrl

Interface
REQ-001 Parameter: W, default 16, operand width in bits (legal 4..32).
REQ-002 Parameter: NOPS, fixed at 17, number of operands summed per job.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset is asynchronous and active-low.
REQ-005 in_valid  input  1  job request; operands on ops are valid.
REQ-006 in_ready  output  1  block can accept a job this cycle.
REQ-007 ops  input  17*W  operand j occupies bits [j*W+W-1 : j*W], j=0..16.
REQ-008 abort  input  1  synchronous job cancel.
REQ-009 out_valid  output  1  sum holds a completed result.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 sum  output  W+5  exact unsigned sum of the 17 operands.
REQ-012 busy  output  1  high in RUN state.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE, encoded in a registered state variable.
REQ-014 in_ready SHALL equal (state==IDLE); a job SHALL be accepted on the edge where in_valid and in_ready are both high.
REQ-015 On acceptance: ops captured into an operand register, column counter cleared to 0, carry state cleared, result register cleared, state -> RUN.
REQ-016 In RUN, each cycle SHALL process one bit column k (LSB first): column vector = bit k of each captured operand, zero for k>=W.
REQ-017 Column datapath: 17-input column compressor; column carry outputs registered and fed back as carry inputs of column k+1 on the next cycle.
REQ-018 Sum bit produced for column k SHALL be written to sum register bit k; no other bit modified.
REQ-019 RUN SHALL last exactly W+5 cycles (k = 0..W+4); carry state after column W+4 is guaranteed zero since 17*(2^W-1) < 2^(W+5).
REQ-020 After column W+4: state -> DONE; out_valid high on the following cycle; latency acceptance-edge to out_valid = W+6 cycles.
REQ-021 In DONE, sum and out_valid SHALL hold stable until out_valid && out_ready; on that edge state -> IDLE, out_valid low next cycle.
REQ-022 No new job accepted in RUN or DONE; in_valid ignored there (ops not sampled).
REQ-023 abort high in RUN or DONE SHALL return state to IDLE on that edge, out_valid low, result discarded; abort in IDLE has no effect.
REQ-024 abort and in_valid both high in IDLE: job accepted (abort ignored).
REQ-025 abort and out_ready both high in DONE: abort wins; result counted as dropped, same next state (IDLE).
REQ-026 Result SHALL equal sum of the 17 operands as unsigned integers; no truncation, no overflow flag required.
REQ-027 Column counter width SHALL be ceil(log2(W+5)); no wrap permitted within a job.
REQ-028 busy SHALL equal (state==RUN).

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, counter 0, carry state 0, sum 0, out_valid 0, busy 0, in_ready 1 after release.
REQ-030 Reset asserted mid-RUN or in DONE SHALL discard the job with no partial output.
REQ-031 First job SHALL be accepted on the first rising edge after rst_n deasserts if in_valid is high.

Verification
REQ-032 W=16, all ops 0, out_ready=1 -> out_valid 22 cycles after accept, sum=0.
REQ-033 W=16, all ops 0xFFFF -> sum=0x10FFEF (1114095).
REQ-034 W=16, op0=0x0001, op16=0xFFFF, others 0 -> sum=0x10000; out_ready held low 10 cycles -> sum and out_valid stable throughout, in_ready 0.
REQ-035 Random ops, 1000 jobs, random out_ready gaps -> every sum matches golden 17-operand add; back-to-back jobs start the cycle after handshake.
REQ-036 rst_n pulsed low at column 8 of a job -> out_valid stays 0, in_ready 1 after release; next job (ops j = j+1) -> sum=153.
REQ-037 abort at column 3 -> IDLE next cycle, no out_valid; abort with out_ready in DONE -> no transfer counted, IDLE.

Source files
------------

// File: rtl/compressor_seq_ctrl.sv
// Bit-serial 17-operand adder: one bit column per cycle goes through a column
// compressor, and the column carry is fed back into the next column.
module compressor_seq_ctrl #(
    parameter int W = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [17*W-1:0]   ops_i,
    input  logic              abort_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [W+4:0]      sum_o,
    output logic              busy_o
);

    localparam int NOPS = 17;
    localparam int SW   = W + 5;
    localparam int CW   = $clog2(SW);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST_COL = CW'(SW - 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [4:0]         carry_q, carry_d;
    logic [SW-1:0]      sum_q, sum_d;
    logic [NOPS*W-1:0]  ops_q, ops_d;
    logic               out_valid_q, out_valid_d;

    logic [NOPS-1:0]    colBits;
    logic [W-1:0]       shifted;
    logic [5:0]         colTotal;

    // Column k holds bit k of every operand; shifting past the operand width
    // naturally yields zero for the upper W..W+4 columns.
    always_comb begin
        colBits  = '0;
        shifted  = '0;
        colTotal = 6'(carry_q);
        for (int j = 0; j < NOPS; j++) begin
            shifted    = ops_q[j*W +: W] >> cnt_q;
            colBits[j] = shifted[0];
            colTotal   = colTotal + 6'(colBits[j]);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        ops_d       = ops_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    ops_d   = ops_i;
                    cnt_d   = '0;
                    carry_d = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    sum_d[cnt_q] = colTotal[0];
                    carry_d      = colTotal[5:1];
                    if (cnt_q == LAST_COL) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                // Abort takes priority over a pending handshake: the result is dropped.
                if (abort_i || (out_valid_q && out_ready_i)) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= '0;
            sum_q       <= '0;
            ops_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            ops_q       <= ops_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign busy_o      = (state_q == RUN);
    assign out_valid_o = out_valid_q;
    assign sum_o       = sum_q;

endmodule

// File: tb/tb_compressor_seq_ctrl.sv
// Self-checking bench for compressor_seq_ctrl: a job-age reference model is
// compared every cycle, plus directed jobs with hand-computed results.
module tb_compressor_seq_ctrl;

    localparam int W    = 16;
    localparam int NOPS = 17;
    localparam int SW   = W + 5;
    localparam int LAT  = W + 6;

    logic              clk = 1'b0;
    logic              rstN = 1'b0;
    logic              inValid;
    logic              inReady;
    logic [NOPS*W-1:0] ops;
    logic              abortReq;
    logic              outValid;
    logic              outReady;
    logic [SW-1:0]     sum;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;

    bit     mActive = 1'b0;
    int     mAge    = 0;
    longint mExp    = 0;
    int     mJobs   = 0;

    always #5 clk = ~clk;

    compressor_seq_ctrl #(.W(W)) dut (
        .clk_i       (clk),
        .rst_n_i     (rstN),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .ops_i       (ops),
        .abort_i     (abortReq),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .sum_o       (sum),
        .busy_o      (busy)
    );

    function automatic longint goldenSum(input logic [NOPS*W-1:0] v);
        longint s = 0;
        for (int j = 0; j < NOPS; j++) s += longint'(v[j*W +: W]);
        return s;
    endfunction

    // Model tracks only whether a job is live and how many edges it has aged:
    // busy for W+5 cycles, one quiet cycle, then the result is offered.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mActive = 1'b0;
            mAge    = 0;
            mExp    = 0;
        end else if (!mActive) begin
            if (inValid) begin
                mActive = 1'b1;
                mAge    = 0;
                mExp    = goldenSum(ops);
                mJobs++;
            end
        end else if (abortReq) begin
            mActive = 1'b0;
        end else if (mAge >= LAT && outReady) begin
            mActive = 1'b0;
        end else if (mAge < LAT) begin
            mAge++;
        end
    end

    task automatic checkValue(input string name, input longint actual, input longint expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        checkValue("in_ready", longint'(inReady), longint'(!mActive));
        checkValue("busy", longint'(busy), longint'(mActive && mAge < W + 5));
        checkValue("out_valid", longint'(outValid), longint'(mActive && mAge >= LAT));
        if (mActive && mAge >= LAT) checkValue("sum", longint'(sum), mExp);
    endtask

    always @(negedge clk) checkOutput();

    task automatic applyStimulus(input logic v, input logic [NOPS*W-1:0] o,
                                 input logic a, input logic r);
        inValid  = v;
        ops      = o;
        abortReq = a;
        outReady = r;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!inReady && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!inReady) checkValue("idle_timeout", longint'(inReady), 1);
    endtask

    // Runs one job, checks latency and the literal result, optionally stalls
    // the consumer and checks that the offered result holds still.
    task automatic directedJob(input string name, input logic [NOPS*W-1:0] o,
                               input longint expSum, input int stall);
        int lat = 0;
        applyStimulus(1'b1, o, 1'b0, stall == 0);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        checkValue({name, "_model"}, mExp, expSum);
        while (!outValid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkValue({name, "_latency"}, lat, LAT);
        checkValue({name, "_sum"}, longint'(sum), expSum);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            checkValue({name, "_hold_sum"}, longint'(sum), expSum);
            checkValue({name, "_hold_valid"}, longint'(outValid), 1);
            checkValue({name, "_hold_ready"}, longint'(inReady), 0);
        end
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        checkValue({name, "_drop_valid"}, longint'(outValid), 0);
        checkValue({name, "_back_idle"}, longint'(inReady), 1);
    endtask

    initial begin
        logic [NOPS*W-1:0] v;
        int cycles;

        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkValue("reset_valid", longint'(outValid), 0);
        checkValue("reset_sum", longint'(sum), 0);
        rstN = 1'b1;

        // Job accepted on the very first edge after reset release.
        directedJob("zeros", '0, 0, 0);

        for (int j = 0; j < NOPS; j++) v[j*W +: W] = 16'hFFFF;
        directedJob("all_ones", v, 64'd1114095, 0);

        v = '0;
        v[0 +: W]      = 16'h0001;
        v[16*W +: W]   = 16'hFFFF;
        directedJob("stall", v, 64'h10000, 10);

        // Reset pulse while column 8 is being processed.
        for (int j = 0; j < NOPS; j++) v[j*W +: W] = 16'($urandom);
        applyStimulus(1'b1, v, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rstN = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        checkValue("rst_mid_valid", longint'(outValid), 0);
        checkValue("rst_mid_ready", longint'(inReady), 1);
        for (int j = 0; j < NOPS; j++) v[j*W +: W] = 16'(j + 1);
        directedJob("after_reset", v, 153, 0);

        // Abort while column 3 is being processed.
        applyStimulus(1'b1, v, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        abortReq = 1'b1;
        @(posedge clk);
        #1;
        abortReq = 1'b0;
        checkValue("abort_run_ready", longint'(inReady), 1);
        checkValue("abort_run_busy", longint'(busy), 0);
        repeat (30) @(posedge clk);
        #1;
        checkValue("abort_run_novalid", longint'(outValid), 0);

        // Abort together with out_ready while the result is offered.
        applyStimulus(1'b1, v, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        cycles = 0;
        while (!outValid && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkValue("abort_done_reached", longint'(outValid), 1);
        abortReq = 1'b1;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        abortReq = 1'b0;
        outReady = 1'b0;
        checkValue("abort_done_valid", longint'(outValid), 0);
        checkValue("abort_done_ready", longint'(inReady), 1);

        // Randomized traffic until the model has seen 1000 more jobs.
        waitIdle();
        begin
            int target = mJobs + 1000;
            cycles = 0;
            while (mJobs < target && cycles < 80000) begin
                for (int j = 0; j < NOPS; j++) begin
                    case ($urandom_range(9))
                        0:       v[j*W +: W] = 16'hFFFF;
                        1:       v[j*W +: W] = 16'h0000;
                        default: v[j*W +: W] = 16'($urandom);
                    endcase
                end
                applyStimulus($urandom_range(9) < 8, v, $urandom_range(399) == 0,
                              $urandom_range(1) == 1);
                @(posedge clk);
                #1;
                cycles++;
            end
            if (mJobs < target) checkValue("random_jobs", mJobs, target);
        end

        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        waitIdle();
        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
